// File: rtl/img_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// img_seq_pkg
// Shared types and constants for the image frame sequencer.
//   seq_state_t : frame sequencing states (IDLE, CLEAR, RUN, DONE)
//   IMG_W/IMG_H : image geometry in pixels
//   PIX_W       : pixel width in bits
// ---------------------------------------------------------------------------
package img_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int PIX_W = 8;

endpackage

// File: rtl/img_frame_sequencer.sv
// ---------------------------------------------------------------------------
// img_frame_sequencer
// Moves one image frame from a ready/valid pixel source into the image FIFO
// and drains it to a ready/valid pixel consumer, tagging the final pixel.
// The FIFO is reset before and after every frame because its pointers do
// not wrap.
//
// Ports
//   clk, reset_n            clock and synchronous active-low reset
//   start, abort            1-cycle control pulses
//   busy, frame_done        frame status
//   src_valid/src_data/src_ready      pixel source handshake
//   pix_valid/pix_data/pix_last/pix_ready  pixel consumer handshake
//   fifo_rst/fifo_wn/fifo_rn/fifo_datain   FIFO control and write data
//   fifo_dataout/fifo_full/fifo_empty      FIFO read data and status
// ---------------------------------------------------------------------------
module img_frame_sequencer
    import img_seq_pkg::*;
#(
    parameter int FRAME_PIXELS = IMG_W * IMG_H,
    parameter int CW           = $clog2(FRAME_PIXELS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_last,
    input  logic             pix_ready,
    output logic             fifo_rst,
    output logic             fifo_wn,
    output logic             fifo_rn,
    output logic [PIX_W-1:0] fifo_datain,
    input  logic [PIX_W-1:0] fifo_dataout,
    input  logic             fifo_full,
    input  logic             fifo_empty
);

    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_PIXELS);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_PIXELS - 1);

    seq_state_t    state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          in_run;
    logic          rd_go;
    logic          wr_ok;

    assign in_run = (state == RUN);

    // A read is only issued when the output register is free or being
    // emptied this cycle, so a stalled consumer never loses a pixel.
    assign rd_go = in_run && !fifo_empty && (rd_cnt < FRAME_CNT)
                   && (!pix_valid || pix_ready);

    // The FIFO handles one operation per cycle; reads take priority so the
    // consumer side never starves while the source is streaming.
    assign wr_ok = in_run && (wr_cnt < FRAME_CNT) && !fifo_full && !rd_go;

    assign fifo_rn     = rd_go;
    assign src_ready   = wr_ok;
    assign fifo_wn     = src_valid && wr_ok;
    assign fifo_datain = src_data;

    // The FIFO holds its read data until the next read strobe, so the
    // output pixel stays stable while the consumer stalls.
    assign pix_data = fifo_dataout;

    assign busy = (state != IDLE);

    // The FIFO is also held in reset while the sequencer itself is in reset.
    assign fifo_rst = !reset_n || (state == CLEAR) || (state == DONE);

    // Frame FSM, pixel counters and the registered output valid/last flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                    end
                end

                CLEAR: begin
                    wr_cnt    <= '0;
                    rd_cnt    <= '0;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    state     <= abort ? DONE : RUN;
                end

                RUN: begin
                    if (abort) begin
                        state     <= DONE;
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                    end else if (pix_valid && pix_last && pix_ready) begin
                        state      <= DONE;
                        pix_valid  <= 1'b0;
                        pix_last   <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        if (fifo_wn) begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                        if (rd_go) begin
                            pix_valid <= 1'b1;
                            rd_cnt    <= rd_cnt + 1'b1;
                            pix_last  <= (rd_cnt == LAST_IDX);
                        end else if (pix_valid && pix_ready) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_img_frame_sequencer
// Directed bench for img_frame_sequencer paired with a small behavioural
// image FIFO (non-wrapping pointers, limited occupancy so backpressure shows).
// ---------------------------------------------------------------------------
module tb_img_frame_sequencer;

    localparam int NPIX     = 784;
    localparam int FIFO_CAP = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'd0;
    logic       pix_ready = 1'b0;

    logic       busy;
    logic       frame_done;
    logic       src_ready;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       fifo_rst;
    logic       fifo_wn;
    logic       fifo_rn;
    logic [7:0] fifo_datain;
    logic [7:0] fifo_dataout;
    logic       fifo_full;
    logic       fifo_empty;

    always #5 clk = ~clk;

    img_frame_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .frame_done   (frame_done),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .pix_ready    (pix_ready),
        .fifo_rst     (fifo_rst),
        .fifo_wn      (fifo_wn),
        .fifo_rn      (fifo_rn),
        .fifo_datain  (fifo_datain),
        .fifo_dataout (fifo_dataout),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty)
    );

    // Behavioural image FIFO: registered read data held until the next read,
    // write wins if both strobes are ever seen together.
    logic [7:0] fmem [0:1023];
    int         wptr = 0;
    int         rptr = 0;
    logic [7:0] fout = 8'd0;

    always @(posedge clk) begin
        if (fifo_rst) begin
            wptr <= 0;
            rptr <= 0;
        end else if (fifo_wn) begin
            if (wptr < 1024) fmem[wptr] <= fifo_datain;
            wptr <= wptr + 1;
        end else if (fifo_rn) begin
            if (rptr < 1024) fout <= fmem[rptr];
            rptr <= rptr + 1;
        end
    end

    assign fifo_dataout = fout;
    assign fifo_full    = ((wptr - rptr) >= FIFO_CAP);
    assign fifo_empty   = (wptr == rptr);

    int checks = 0;
    int passes = 0;

    int src_idx, exp_idx, data_err, last_err, last_cnt;
    int overlap_err, wn_err, done_cnt, rst_busy_cnt, rd_issued;
    int first_bad_got, first_bad_exp;

    task automatic clear_stats();
        src_idx = 0; exp_idx = 0; data_err = 0; last_err = 0; last_cnt = 0;
        overlap_err = 0; wn_err = 0; done_cnt = 0; rst_busy_cnt = 0;
        rd_issued = 0; first_bad_got = 0; first_bad_exp = 0;
    endtask

    // One clock: drive inputs on the falling edge, observe 1ns later and
    // account for handshakes that will complete on the next rising edge.
    task automatic do_cycle(input logic sv, input logic rdy,
                            input logic st, input logic ab);
        @(negedge clk);
        src_valid = sv;
        src_data  = src_idx[7:0];
        pix_ready = rdy;
        start     = st;
        abort     = ab;
        #1;
        if (fifo_wn && fifo_rn) overlap_err++;
        if (fifo_wn !== (src_valid && src_ready)) wn_err++;
        if (busy && fifo_rst) rst_busy_cnt++;
        if (fifo_rn) rd_issued++;
        if (frame_done) done_cnt++;
        if (pix_valid && pix_ready) begin
            if (pix_data !== exp_idx[7:0]) begin
                if (data_err == 0) begin
                    first_bad_got = int'(pix_data);
                    first_bad_exp = exp_idx % 256;
                end
                data_err++;
            end
            if (pix_last !== (exp_idx == NPIX - 1)) last_err++;
            if (pix_last) last_cnt++;
            exp_idx++;
        end
        if (src_valid && src_ready) src_idx++;
    endtask

    // Runs cycles until the sequencer has been busy and returned to idle.
    task automatic run_frame(input int sv_pct, input int rdy_pct,
                             input bit storm, output bit timed_out);
        bit   seen_busy;
        logic sv, rdy, st;
        seen_busy = 0;
        timed_out = 1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            sv  = ($urandom_range(99) < sv_pct);
            rdy = ($urandom_range(99) < rdy_pct);
            st  = storm && seen_busy && (exp_idx < 700) && (cyc % 37 == 5);
            do_cycle(sv, rdy, st, 1'b0);
            if (busy) seen_busy = 1;
            else if (seen_busy) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_stats();
        repeat (3) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_rst !== 1'b1) $display("[TB] FAIL reset_fifo_rst: got %b, expected 1", fifo_rst);
        else passes++;
        checks++;
        if ({busy, pix_valid, pix_last, frame_done, src_ready, fifo_wn, fifo_rn} !== 7'b0)
            $display("[TB] FAIL reset_outputs: got %b, expected 0000000",
                     {busy, pix_valid, pix_last, frame_done, src_ready, fifo_wn, fifo_rn});
        else passes++;
        reset_n = 1'b1;
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({fifo_rst, busy} !== 2'b00) $display("[TB] FAIL idle_after_reset: got %b, expected 00", {fifo_rst, busy});
        else passes++;
    endtask

    task automatic test_stream();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(100, 100, 1'b0, to);
        checks++;
        if (to !== 1'b0) $display("[TB] FAIL stream_timeout: got %b, expected 0", to);
        else passes++;
        checks++;
        if (exp_idx !== NPIX) $display("[TB] FAIL stream_count: got %0d, expected %0d", exp_idx, NPIX);
        else passes++;
        checks++;
        if (data_err !== 0) $display("[TB] FAIL stream_data: got %0d errors (first %0d vs %0d), expected 0",
                                     data_err, first_bad_got, first_bad_exp);
        else passes++;
        checks++;
        if ({last_err, last_cnt} !== {32'd0, 32'd1})
            $display("[TB] FAIL stream_last: got err %0d cnt %0d, expected err 0 cnt 1", last_err, last_cnt);
        else passes++;
        checks++;
        if (done_cnt !== 1) $display("[TB] FAIL stream_done: got %0d, expected 1", done_cnt);
        else passes++;
        checks++;
        if (rst_busy_cnt !== 2) $display("[TB] FAIL stream_fifo_rst: got %0d cycles, expected 2", rst_busy_cnt);
        else passes++;
        checks++;
        if ({overlap_err, wn_err} !== 64'd0)
            $display("[TB] FAIL stream_strobes: got overlap %0d wn %0d, expected 0 0", overlap_err, wn_err);
        else passes++;
    endtask

    task automatic test_backpressure();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (60) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rd_issued !== 1) $display("[TB] FAIL bp_reads: got %0d, expected 1", rd_issued);
        else passes++;
        checks++;
        if (src_idx !== FIFO_CAP + 1) $display("[TB] FAIL bp_writes: got %0d, expected %0d", src_idx, FIFO_CAP + 1);
        else passes++;
        checks++;
        if ({src_ready, pix_valid, pix_data} !== {1'b0, 1'b1, 8'd0})
            $display("[TB] FAIL bp_hold: got rdy %b vld %b data %0d, expected 0 1 0", src_ready, pix_valid, pix_data);
        else passes++;
        run_frame(100, 100, 1'b0, to);
        checks++;
        if ({to, exp_idx, data_err, done_cnt} !== {1'b0, NPIX, 32'd0, 32'd1})
            $display("[TB] FAIL bp_release: got to %b beats %0d errs %0d done %0d, expected 0 %0d 0 1",
                     to, exp_idx, data_err, done_cnt, NPIX);
        else passes++;
    endtask

    task automatic test_random();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(50, 50, 1'b0, to);
        checks++;
        if (to !== 1'b0) $display("[TB] FAIL rand_timeout: got %b, expected 0", to);
        else passes++;
        checks++;
        if (overlap_err !== 0) $display("[TB] FAIL rand_overlap: got %0d, expected 0", overlap_err);
        else passes++;
        checks++;
        if ({exp_idx, data_err, last_err, done_cnt} !== {NPIX, 32'd0, 32'd0, 32'd1})
            $display("[TB] FAIL rand_frame: got beats %0d errs %0d lasterr %0d done %0d, expected %0d 0 0 1",
                     exp_idx, data_err, last_err, done_cnt, NPIX);
        else passes++;
    endtask

    task automatic test_abort();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2000 && exp_idx < 100; i++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (exp_idx < 100) $display("[TB] FAIL abort_reach100: got %0d, expected >=100", exp_idx);
        else passes++;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({pix_valid, fifo_rst, busy, frame_done} !== 4'b0110)
            $display("[TB] FAIL abort_done_state: got %b, expected 0110", {pix_valid, fifo_rst, busy, frame_done});
        else passes++;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({busy, done_cnt} !== {1'b0, 32'd0})
            $display("[TB] FAIL abort_idle: got busy %b done %0d, expected 0 0", busy, done_cnt);
        else passes++;
        // start and abort together in IDLE: start must win
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        run_frame(100, 100, 1'b0, to);
        checks++;
        if ({to, exp_idx, data_err, last_err, done_cnt} !== {1'b0, NPIX, 32'd0, 32'd0, 32'd1})
            $display("[TB] FAIL abort_fresh_frame: got to %b beats %0d errs %0d lasterr %0d done %0d, expected 0 %0d 0 0 1",
                     to, exp_idx, data_err, last_err, done_cnt, NPIX);
        else passes++;
    endtask

    task automatic test_mid_reset();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (50) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_rst !== 1'b1) $display("[TB] FAIL midrst_comb: got %b, expected 1", fifo_rst);
        else passes++;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({fifo_rst, busy, pix_valid, pix_last, frame_done, src_ready, fifo_wn, fifo_rn} !== 8'b1000_0000)
            $display("[TB] FAIL midrst_outputs: got %b, expected 10000000",
                     {fifo_rst, busy, pix_valid, pix_last, frame_done, src_ready, fifo_wn, fifo_rn});
        else passes++;
        reset_n = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(100, 100, 1'b0, to);
        checks++;
        if ({to, exp_idx, data_err, last_err, done_cnt} !== {1'b0, NPIX, 32'd0, 32'd0, 32'd1})
            $display("[TB] FAIL midrst_next_frame: got to %b beats %0d errs %0d lasterr %0d done %0d, expected 0 %0d 0 0 1",
                     to, exp_idx, data_err, last_err, done_cnt, NPIX);
        else passes++;
    endtask

    task automatic test_start_storm();
        bit to;
        clear_stats();
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        run_frame(100, 100, 1'b1, to);
        repeat (5) do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({to, exp_idx, data_err} !== {1'b0, NPIX, 32'd0})
            $display("[TB] FAIL storm_frame: got to %b beats %0d errs %0d, expected 0 %0d 0", to, exp_idx, data_err, NPIX);
        else passes++;
        checks++;
        if ({busy, done_cnt} !== {1'b0, 32'd1})
            $display("[TB] FAIL storm_single_done: got busy %b done %0d, expected 0 1", busy, done_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_abort();
        test_mid_reset();
        test_start_storm();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
